qdr_pingpong_scheduler: RTL

- Bank scheduler for the QDR frame buffer, clocked on the QDR user clock.
- Splits QDR address space into two frame banks (bank 0 at 20'h00000, bank 1 at BANK_WORDS) and owns their FREE/WRITING/FULL/READING lifecycle.
- Grants banks to the frame write sequencer and dispatches filled banks, oldest first, to the read sequencer, carrying each frame's calculation tag from write to read.
- Replaces the implicit ping toggle, so a slow reader stalls the writer instead of being overwritten.

---
 rtl/qdr_pingpong_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/qdr_pingpong_scheduler.sv
// qdr_pingpong_scheduler
// Bank scheduler for the QDR frame buffer. The QDR address space is split into
// two frame banks (bank 0 at address 0, bank 1 at BANK_WORDS). Each bank moves
// through the lifecycle FREE -> WRITING -> FULL -> READING -> FREE. The writer
// gets a bank on request, and filled banks go to the reader oldest first. The
// frame tag written with a bank is returned when that bank is dispatched. A slow
// reader stalls the writer rather than letting it overwrite an unread bank.
//
// Handshakes: wr_req is a level that the writer holds until the one-cycle
// wr_grant pulse. wr_done and rd_done are one-cycle pulses. They count only
// while wr_active / rd_active is set; otherwise they are ignored and set
// seq_err. rd_start is a one-cycle pulse. rd_base_addr and rd_tag are valid
// with it and hold until the next dispatch.
//
// Ports:
//   qdr_user_clk, rst_n           clock, async active-low reset
//   phy_init_done                 gates new grants and dispatches
//   wr_req, wr_tag, wr_done       writer request / frame tag / bank written
//   wr_grant, wr_base_addr        bank granted / its base address
//   wr_active                     a bank is in WRITING
//   rd_start, rd_base_addr, rd_tag  read dispatched / base / stored tag
//   rd_done, rd_active            bank fully read / a bank is in READING
//   stall                         writer waiting with no FREE bank
//   frames_written, frames_read   valid done-pulse counters (wrap)
//   seq_err                       sticky protocol-error flag
module qdr_pingpong_scheduler #(
  parameter int BANK_WORDS = 524288,
  parameter int ADDR_W     = 20,
  parameter int TAG_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic              qdr_user_clk,
  input  logic              rst_n,
  input  logic              phy_init_done,
  input  logic              wr_req,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_done,
  output logic              wr_grant,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic              wr_active,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic [TAG_W-1:0]  rd_tag,
  input  logic              rd_done,
  output logic              rd_active,
  output logic              stall,
  output logic [CNT_W-1:0]  frames_written,
  output logic [CNT_W-1:0]  frames_read,
  output logic              seq_err
);

  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK_WORDS);

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  bank_state_t      bank_state [2];
  logic [TAG_W-1:0] bank_tag   [2];
  logic             last_wr_bank;
  logic             wr_bank;
  logic             rd_bank;

  // Order of filled banks. At most two banks can be FULL, so two entries
  // are always enough.
  logic             fifo_q [2];
  logic [1:0]       fifo_cnt;

  logic wr_done_ok;
  logic rd_done_ok;
  logic any_free;
  logic grant;
  logic dispatch;
  logic grant_bank;
  logic pop_bank;

  // Every decision uses the state from before the edge. A bank freed by
  // rd_done therefore becomes grantable one edge later.
  assign wr_done_ok = wr_done & wr_active;
  assign rd_done_ok = rd_done & rd_active;
  assign any_free   = (bank_state[0] == BANK_FREE) | (bank_state[1] == BANK_FREE);
  assign grant      = wr_req & phy_init_done & ~wr_active & any_free;
  assign dispatch   = phy_init_done & ~rd_active & (fifo_cnt != 2'd0);
  // Alternate banks when possible, otherwise reuse the bank just written.
  assign grant_bank = (bank_state[~last_wr_bank] == BANK_FREE) ? ~last_wr_bank : last_wr_bank;
  assign pop_bank   = fifo_q[0];
  assign stall      = wr_req & ~wr_active & ~any_free;

  always_ff @(posedge qdr_user_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bank_state[i] <= BANK_FREE;
        bank_tag[i]   <= '0;
        fifo_q[i]     <= 1'b0;
      end
      fifo_cnt       <= 2'd0;
      last_wr_bank   <= 1'b1;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      wr_grant       <= 1'b0;
      wr_base_addr   <= '0;
      wr_active      <= 1'b0;
      rd_start       <= 1'b0;
      rd_base_addr   <= '0;
      rd_tag         <= '0;
      rd_active      <= 1'b0;
      frames_written <= '0;
      frames_read    <= '0;
      seq_err        <= 1'b0;
    end else begin
      wr_grant <= grant;
      rd_start <= dispatch;

      // grant requires !wr_active and wr_done_ok requires wr_active, so the
      // two cannot happen together. The same holds for dispatch and rd_done_ok.
      if (grant) begin
        bank_state[grant_bank] <= BANK_WRITING;
        wr_bank                <= grant_bank;
        last_wr_bank           <= grant_bank;
        wr_base_addr           <= grant_bank ? BANK1_BASE : '0;
        wr_active              <= 1'b1;
      end

      if (wr_done_ok) begin
        bank_state[wr_bank] <= BANK_FULL;
        bank_tag[wr_bank]   <= wr_tag;
        wr_active           <= 1'b0;
        frames_written      <= frames_written + CNT_W'(1);
      end

      if (dispatch) begin
        bank_state[pop_bank] <= BANK_READING;
        rd_bank              <= pop_bank;
        rd_base_addr         <= pop_bank ? BANK1_BASE : '0;
        rd_tag               <= bank_tag[pop_bank];
        rd_active            <= 1'b1;
      end

      if (rd_done_ok) begin
        bank_state[rd_bank] <= BANK_FREE;
        rd_active           <= 1'b0;
        frames_read         <= frames_read + CNT_W'(1);
      end

      unique case ({wr_done_ok, dispatch})
        2'b10: begin
          fifo_q[fifo_cnt[0]] <= wr_bank;
          fifo_cnt            <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          // The oldest entry leaves and the new one goes behind any survivor.
          if (fifo_cnt == 2'd1) begin
            fifo_q[0] <= wr_bank;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= wr_bank;
          end
        end
        default: ;
      endcase

      if ((wr_done & ~wr_active) | (rd_done & ~rd_active)) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule
